io_command_arbiter: RTL and testbench

//  Shares one IO command interface (the per-port store-data assembler) among REQCOUNT command sources.

---
 rtl/io_arb_pkg.sv | 14 +
 rtl/io_rr_picker.sv | 39 +++
 rtl/io_command_arbiter.sv | 135 +++++++++++++
 tb/tb_io_command_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types and helpers for the IO command arbiter: FSM state encoding and
// a wrapping index increment used to advance the round-robin pointer.
package io_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] count);
      return ((idx + 32'd1) >= count) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage

// File: rtl/io_rr_picker.sv
// Combinational round-robin picker: finds the first set request at or after
// i_ptr, wrapping modulo REQCOUNT.
module io_rr_picker
   import io_arb_pkg::*;
#(
   parameter int REQCOUNT   = 4,
   parameter int IDBITWIDTH = $clog2(REQCOUNT)
) (
   input  logic [REQCOUNT-1:0]   i_req_vec,
   input  logic [IDBITWIDTH-1:0] i_ptr,
   output logic                  o_any,
   output logic [IDBITWIDTH-1:0] o_index
);

   localparam int SW = IDBITWIDTH + 1;

   logic [2*REQCOUNT-1:0] w_dbl;
   logic [REQCOUNT-1:0]   w_rot;
   logic [IDBITWIDTH-1:0] w_off;
   logic [SW-1:0]         w_sum;

   // Rotate so i_ptr sits at bit 0, take the lowest set bit, then rotate the index back
   always_comb begin
      w_dbl = {i_req_vec, i_req_vec};
      w_rot = REQCOUNT'(w_dbl >> i_ptr);
      w_off = '0;
      for (int k = REQCOUNT - 1; k >= 0; k--) begin
         w_off = w_rot[k] ? IDBITWIDTH'(k) : w_off;
      end
      w_sum = {1'b0, i_ptr} + {1'b0, w_off};
      if (w_sum >= SW'(REQCOUNT)) begin
         o_index = IDBITWIDTH'(w_sum - SW'(REQCOUNT));
      end else begin
         o_index = w_sum[IDBITWIDTH-1:0];
      end
      o_any = |i_req_vec;
   end

endmodule

// File: rtl/io_command_arbiter.sv
// Round-robin arbiter sharing one IO command interface among REQCOUNT requesters;
// the grant is locked across multi-beat commands, with an optional idle timeout.
module io_command_arbiter
   import io_arb_pkg::*;
#(
   parameter int DATABITWIDTH = 16,
   parameter int REQCOUNT     = 4,
   parameter int IDBITWIDTH   = $clog2(REQCOUNT),
   parameter int LOCKTIMEOUT  = 64
) (
   input  logic                           clk,
   input  logic                           async_rst_n,
   input  logic                           clk_en,
   input  logic [REQCOUNT-1:0]            ReqACK,
   output logic [REQCOUNT-1:0]            ReqREQ,
   input  logic [REQCOUNT-1:0]            ReqLast,
   input  logic [4*REQCOUNT-1:0]          ReqMinorOpcode,
   input  logic [DATABITWIDTH*REQCOUNT-1:0] ReqDataAddr,
   input  logic [DATABITWIDTH*REQCOUNT-1:0] ReqData,
   output logic                           CommandOutACK,
   input  logic                           CommandOutREQ,
   output logic [3:0]                     MinorOpcodeOut,
   output logic [DATABITWIDTH-1:0]        DataAddrOut,
   output logic [DATABITWIDTH-1:0]        DataOut,
   output logic [IDBITWIDTH-1:0]          GrantID,
   output logic                           Locked,
   output logic                           TimeoutErr
);

   localparam int                CNTW       = (LOCKTIMEOUT > 1) ? $clog2(LOCKTIMEOUT) : 1;
   localparam logic [CNTW-1:0]   CNT_MAX    = CNTW'((LOCKTIMEOUT > 0) ? (LOCKTIMEOUT - 1) : 0);
   localparam bit                TIMEOUT_EN = (LOCKTIMEOUT != 0);

   arb_state_t            r_state;
   logic [IDBITWIDTH-1:0] r_ptr;
   logic [IDBITWIDTH-1:0] r_lock_id;
   logic [CNTW-1:0]       r_idle_cnt;
   logic                  r_timeout_err;

   logic                  w_pick_any;
   logic [IDBITWIDTH-1:0] w_pick_idx;
   logic [IDBITWIDTH-1:0] w_grant;
   logic                  w_ack;
   logic                  w_xfer;
   logic                  w_last;
   logic [31:0]           w_sel;

   io_rr_picker #(
      .REQCOUNT   (REQCOUNT),
      .IDBITWIDTH (IDBITWIDTH)
   ) u_picker (
      .i_req_vec (ReqACK),
      .i_ptr     (r_ptr),
      .o_any     (w_pick_any),
      .o_index   (w_pick_idx)
   );

   // Grant selection, handshake qualification and the zero-latency output mux
   always_comb begin
      if (!async_rst_n) begin
         w_grant = '0;
         w_ack   = 1'b0;
      end else if (r_state == ARB_LOCKED) begin
         w_grant = r_lock_id;
         w_ack   = ReqACK[r_lock_id];
      end else begin
         w_grant = w_pick_idx;
         w_ack   = w_pick_any;
      end
      w_sel  = 32'(w_grant);
      w_xfer = w_ack && CommandOutREQ && clk_en;
      w_last = ReqLast[w_grant];

      ReqREQ = '0;
      for (int i = 0; i < REQCOUNT; i++) begin
         ReqREQ[i] = w_xfer && (w_grant == IDBITWIDTH'(i));
      end

      CommandOutACK  = w_ack;
      GrantID        = w_grant;
      MinorOpcodeOut = ReqMinorOpcode[w_sel*4 +: 4];
      DataAddrOut    = ReqDataAddr[w_sel*DATABITWIDTH +: DATABITWIDTH];
      DataOut        = ReqData[w_sel*DATABITWIDTH +: DATABITWIDTH];
      Locked         = (r_state == ARB_LOCKED);
      TimeoutErr     = r_timeout_err;
   end

   // Arbitration FSM: pointer advance, lock capture, idle timeout and sticky error
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_state       <= ARB_IDLE;
         r_ptr         <= '0;
         r_lock_id     <= '0;
         r_idle_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else if (clk_en) begin
         case (r_state)
            ARB_IDLE: begin
               if (w_xfer && w_last) begin
                  r_ptr <= IDBITWIDTH'(wrap_inc(32'(w_grant), 32'(REQCOUNT)));
               end else if (w_xfer) begin
                  r_state    <= ARB_LOCKED;
                  r_lock_id  <= w_grant;
                  r_idle_cnt <= '0;
               end else begin
                  r_state <= ARB_IDLE;
               end
            end
            ARB_LOCKED: begin
               if (w_xfer && w_last) begin
                  r_state <= ARB_IDLE;
                  r_ptr   <= IDBITWIDTH'(wrap_inc(32'(r_lock_id), 32'(REQCOUNT)));
               end else if (w_xfer) begin
                  r_idle_cnt <= '0;
               end else if (TIMEOUT_EN && (r_idle_cnt == CNT_MAX)) begin
                  // Owner went quiet too long: drop the lock so others are not starved
                  r_state       <= ARB_IDLE;
                  r_ptr         <= IDBITWIDTH'(wrap_inc(32'(r_lock_id), 32'(REQCOUNT)));
                  r_timeout_err <= 1'b1;
               end else if (TIMEOUT_EN) begin
                  r_idle_cnt <= r_idle_cnt + CNTW'(1);
               end else begin
                  r_idle_cnt <= r_idle_cnt;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end else begin
         r_state <= r_state;
      end
   end

endmodule

// File: tb/tb_io_command_arbiter.sv
// Directed bench for io_command_arbiter: scoreboard of expected beats plus
// immediate-assertion checks of grant, lock, timeout, clock-enable and reset behaviour.
module tb_io_command_arbiter;

   typedef struct packed {
      logic [1:0]  id;
      logic [3:0]  op;
      logic [15:0] addr;
      logic [15:0] data;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        clk_en;
   logic [3:0]  req_ack;
   logic [3:0]  req_last;
   logic [15:0] req_op;
   logic [63:0] req_addr;
   logic [63:0] req_data;
   logic        cmd_req;

   logic [3:0]  b_op   [4];
   logic [15:0] b_addr [4];
   logic [15:0] b_data [4];

   logic [3:0]  a_req_req;
   logic        a_ack;
   logic [3:0]  a_op;
   logic [15:0] a_addr;
   logic [15:0] a_data;
   logic [1:0]  a_grant;
   logic        a_locked;
   logic        a_terr;

   logic [3:0]  t_req_req;
   logic        t_ack;
   logic [3:0]  t_op;
   logic [15:0] t_addr;
   logic [15:0] t_data;
   logic [1:0]  t_grant;
   logic        t_locked;
   logic        t_terr;

   beat_t sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   io_command_arbiter #(.DATABITWIDTH(16), .REQCOUNT(4), .LOCKTIMEOUT(64)) dut (
      .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en),
      .ReqACK(req_ack), .ReqREQ(a_req_req), .ReqLast(req_last),
      .ReqMinorOpcode(req_op), .ReqDataAddr(req_addr), .ReqData(req_data),
      .CommandOutACK(a_ack), .CommandOutREQ(cmd_req),
      .MinorOpcodeOut(a_op), .DataAddrOut(a_addr), .DataOut(a_data),
      .GrantID(a_grant), .Locked(a_locked), .TimeoutErr(a_terr)
   );

   io_command_arbiter #(.DATABITWIDTH(16), .REQCOUNT(4), .LOCKTIMEOUT(8)) dut_to (
      .clk(clk), .async_rst_n(rst_n), .clk_en(clk_en),
      .ReqACK(req_ack), .ReqREQ(t_req_req), .ReqLast(req_last),
      .ReqMinorOpcode(req_op), .ReqDataAddr(req_addr), .ReqData(req_data),
      .CommandOutACK(t_ack), .CommandOutREQ(cmd_req),
      .MinorOpcodeOut(t_op), .DataAddrOut(t_addr), .DataOut(t_data),
      .GrantID(t_grant), .Locked(t_locked), .TimeoutErr(t_terr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_op   = '0;
      req_addr = '0;
      req_data = '0;
      for (int i = 0; i < 4; i++) begin
         req_op[i*4 +: 4]    = b_op[i];
         req_addr[i*16 +: 16] = b_addr[i];
         req_data[i*16 +: 16] = b_data[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic ack, input logic last,
                          input logic [15:0] addr, input logic [15:0] data);
      req_ack[i]  = ack;
      req_last[i] = last;
      b_op[i]     = 4'(i + 3);
      b_addr[i]   = addr;
      b_data[i]   = data;
   endtask

   task automatic expect_beat(input int i);
      beat_t e;
      e.id   = 2'(i);
      e.op   = b_op[i];
      e.addr = b_addr[i];
      e.data = b_data[i];
      sb_q.push_back(e);
   endtask

   // Sample away from the active edge; a pending transfer must match the scoreboard head
   task automatic sample();
      beat_t e;
      @(negedge clk);
      chk("sb_xfer", 32'(|a_req_req), 32'(sb_q.size() != 0));
      if ((|a_req_req) && (sb_q.size() != 0)) begin
         e = sb_q.pop_front();
         chk("sb_grant",  32'(a_grant),   32'(e.id));
         chk("sb_reqreq", 32'(a_req_req), 32'(4'b0001 << e.id));
         chk("sb_op",     32'(a_op),      32'(e.op));
         chk("sb_addr",   32'(a_addr),    32'(e.addr));
         chk("sb_data",   32'(a_data),    32'(e.data));
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst_n   = 1'b0;
      req_ack = 4'b0000;
      adv();
      rst_n = 1'b1;
   endtask

   initial begin
      int exp1 [4];
      exp1 = '{0, 2, 0, 2};
      rst_n    = 1'b0;
      clk_en   = 1'b1;
      cmd_req  = 1'b1;
      req_ack  = 4'b0000;
      req_last = 4'b0000;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 16'(16'hA000 + i), 16'h0000);

      // Reset state, with a requester already active
      repeat (2) adv();
      req_ack = 4'b0100;
      #2;
      chk("rst_ack",    32'(a_ack),     32'd0);
      chk("rst_grant",  32'(a_grant),   32'd0);
      chk("rst_reqreq", 32'(a_req_req), 32'd0);
      chk("rst_locked", 32'(a_locked),  32'd0);
      chk("rst_terr",   32'(a_terr),    32'd0);
      chk("rst_terr_t", 32'(t_terr),    32'd0);
      adv();
      rst_n   = 1'b1;
      req_ack = 4'b0000;

      // 1: requesters 0 and 2, single-beat commands alternate
      for (int k = 0; k < 4; k++) begin
         set_req(0, 1'b1, 1'b1, 16'hA100, 16'(16'h1100 + k));
         set_req(2, 1'b1, 1'b1, 16'hA102, 16'(16'h1200 + k));
         expect_beat(exp1[k]);
         sample();
         chk("t1_grant", 32'(a_grant), 32'(exp1[k]));
         adv();
      end
      req_ack = 4'b0000;

      // 2: Req1 three-beat command holds the grant against Req0
      set_req(0, 1'b1, 1'b1, 16'hA200, 16'h2000);
      expect_beat(0);
      sample();
      adv();
      for (int b = 1; b <= 3; b++) begin
         set_req(1, 1'b1, (b == 3), 16'hA201, 16'(16'h2100 + b));
         expect_beat(1);
         sample();
         chk("t2_grant",  32'(a_grant),  32'd1);
         chk("t2_locked", 32'(a_locked), 32'(b != 1));
         adv();
      end
      set_req(1, 1'b0, 1'b0, 16'hA201, 16'h0000);
      expect_beat(0);
      sample();
      chk("t2_next_grant", 32'(a_grant),  32'd0);
      chk("t2_unlocked",   32'(a_locked), 32'd0);
      adv();
      req_ack = 4'b0000;

      // 3: locked on Req2 while the interface stalls
      set_req(2, 1'b1, 1'b0, 16'hA302, 16'h2222);
      expect_beat(2);
      sample();
      adv();
      cmd_req = 1'b0;
      set_req(0, 1'b1, 1'b1, 16'hA300, 16'h3000);
      set_req(1, 1'b1, 1'b1, 16'hA301, 16'h3001);
      for (int c = 0; c < 10; c++) begin
         sample();
         chk("t3_locked", 32'(a_locked),  32'd1);
         chk("t3_grant",  32'(a_grant),   32'd2);
         chk("t3_addr",   32'(a_addr),    32'h0000A302);
         chk("t3_data",   32'(a_data),    32'h00002222);
         chk("t3_reqreq", 32'(a_req_req), 32'd0);
         adv();
      end
      cmd_req = 1'b1;
      set_req(2, 1'b1, 1'b1, 16'hA302, 16'h2223);
      expect_beat(2);
      sample();
      adv();
      set_req(2, 1'b0, 1'b0, 16'hA302, 16'h0000);
      expect_beat(0);
      sample();
      chk("t3_after_grant", 32'(a_grant), 32'd0);
      adv();

      // 4: lock timeout on the LOCKTIMEOUT=8 instance
      reset_pulse();
      chk("t4_terr_cleared", 32'(t_terr), 32'd0);
      set_req(1, 1'b1, 1'b1, 16'hA401, 16'h4001);
      expect_beat(1);
      sample();
      adv();
      req_ack = 4'b0000;
      set_req(3, 1'b1, 1'b0, 16'hA403, 16'h4003);
      expect_beat(3);
      sample();
      chk("t4_t_grant3", 32'(t_grant), 32'd3);
      adv();
      set_req(3, 1'b0, 1'b0, 16'hA403, 16'h4003);
      for (int c = 0; c < 8; c++) begin
         sample();
         chk("t4_t_locked", 32'(t_locked), 32'd1);
         chk("t4_t_terr0",  32'(t_terr),   32'd0);
         adv();
      end
      sample();
      chk("t4_t_unlocked", 32'(t_locked), 32'd0);
      chk("t4_t_terr1",    32'(t_terr),   32'd1);
      chk("t4_a_locked",   32'(a_locked), 32'd1);
      cmd_req = 1'b0;
      req_ack = 4'b1111;
      #1;
      chk("t4_t_ptr0",    32'(t_grant), 32'd0);
      chk("t4_a_grant3",  32'(a_grant), 32'd3);
      adv();
      sample();
      chk("t4_t_sticky", 32'(t_terr), 32'd1);
      adv();
      cmd_req = 1'b1;

      // 5: clock enable low freezes state and suppresses transfers
      reset_pulse();
      set_req(1, 1'b1, 1'b1, 16'hA501, 16'h5001);
      expect_beat(1);
      sample();
      adv();
      clk_en = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'(16'hA510 + i), 16'(16'h5100 + i));
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("t5_reqreq", 32'(a_req_req), 32'd0);
         chk("t5_grant",  32'(a_grant),   32'd2);
         chk("t5_locked", 32'(a_locked),  32'd0);
         chk("t5_ack",    32'(a_ack),     32'd1);
         chk("t5_data",   32'(a_data),    32'h00005102);
         adv();
      end
      clk_en   = 1'b1;
      req_last = 4'b1111;
      expect_beat(2);
      sample();
      adv();
      expect_beat(3);
      sample();
      chk("t5_grant_next", 32'(a_grant), 32'd3);
      adv();
      req_ack = 4'b0000;

      // 6: asynchronous reset in the middle of a lock
      set_req(1, 1'b1, 1'b0, 16'hA601, 16'h6001);
      expect_beat(1);
      sample();
      adv();
      cmd_req = 1'b0;
      sample();
      chk("t6_locked", 32'(a_locked), 32'd1);
      chk("t6_ack",    32'(a_ack),    32'd1);
      #2;
      cmd_req = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk("t6_rst_ack",      32'(a_ack),     32'd0);
      chk("t6_rst_locked",   32'(a_locked),  32'd0);
      chk("t6_rst_reqreq",   32'(a_req_req), 32'd0);
      chk("t6_rst_locked_t", 32'(t_locked),  32'd0);
      adv();
      rst_n    = 1'b1;
      cmd_req  = 1'b0;
      req_ack  = 4'b1111;
      req_last = 4'b1111;
      sample();
      chk("t6_grant0",  32'(a_grant),  32'd0);
      chk("t6_idle",    32'(a_locked), 32'd0);
      adv();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
